// File: rtl/secuenciador_resta.sv
// secuenciador_resta: operand sequencer and result register around an external combinational subtractor.
// Optional RESTA_SAT_EN: negative differences are clamped to zero in CALC.
module secuenciador_resta #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             LOAD,
    input  logic             CLEAR,
    output logic [WIDTH-1:0] SUB_A,
    output logic [WIDTH-1:0] SUB_B,
    input  logic [WIDTH-1:0] SUB_OUT,
    output logic [WIDTH-1:0] RESULT,
    output logic             BORROW,
    output logic             ZERO,
    output logic             VALID,
    output logic [1:0]       STATE
);
    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        CALC   = 2'b10,
        SHOW   = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic             borrow_q, borrow_d, zero_q, zero_d, valid_q, valid_d;
    logic             calc_borrow;
    logic [WIDTH-1:0] calc_result;

    // Borrow comes from the registered operands, never from the subtractor output.
    assign calc_borrow = a_q < b_q;
`ifdef RESTA_SAT_EN
    assign calc_result = calc_borrow ? '0 : SUB_OUT;
`else
    assign calc_result = SUB_OUT;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        valid_d  = valid_q;
        if (CLEAR) begin
            state_d  = WAIT_A;
            a_d      = '0;
            b_d      = '0;
            result_d = '0;
            borrow_d = 1'b0;
            zero_d   = 1'b0;
            valid_d  = 1'b0;
        end else begin
            case (state_q)
                WAIT_A: if (LOAD) begin
                    a_d     = DATA_IN;
                    state_d = WAIT_B;
                end
                WAIT_B: if (LOAD) begin
                    b_d     = DATA_IN;
                    state_d = CALC;
                end
                CALC: begin
                    result_d = calc_result;
                    borrow_d = calc_borrow;
                    zero_d   = calc_result == '0;
                    valid_d  = 1'b1;
                    state_d  = SHOW;
                end
                default: if (LOAD) begin
                    a_d     = DATA_IN;
                    valid_d = 1'b0;
                    state_d = WAIT_B;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= WAIT_A;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign SUB_A  = a_q;
    assign SUB_B  = b_q;
    assign RESULT = result_q;
    assign BORROW = borrow_q;
    assign ZERO   = zero_q;
    assign VALID  = valid_q;
    assign STATE  = state_q;
endmodule

// File: tb/tb_secuenciador_resta.sv
// tb_secuenciador_resta: random and directed operations against an arithmetic reference model.
module tb_secuenciador_resta;
    logic       CLK = 1'b0, RST_N = 1'b0, LOAD = 1'b0, CLEAR = 1'b0;
    logic [7:0] DATA_IN = 8'd0;
    logic [7:0] SUB_A, SUB_B, SUB_OUT, RESULT;
    logic       BORROW, ZERO, VALID;
    logic [1:0] STATE;
    int         n_cmp = 0, n_err = 0;
    logic [7:0] last_b = 8'd0;

    // Stand-in for the external combinational subtractor.
    assign SUB_OUT = SUB_A - SUB_B;

    always #5 CLK = ~CLK;

    secuenciador_resta #(.WIDTH(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .DATA_IN(DATA_IN), .LOAD(LOAD), .CLEAR(CLEAR),
        .SUB_A(SUB_A), .SUB_B(SUB_B), .SUB_OUT(SUB_OUT), .RESULT(RESULT),
        .BORROW(BORROW), .ZERO(ZERO), .VALID(VALID), .STATE(STATE)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_state"}, 32'(STATE), 0);
        check({tag, "_sub_a"}, 32'(SUB_A), 0);
        check({tag, "_sub_b"}, 32'(SUB_B), 0);
        check({tag, "_result"}, 32'(RESULT), 0);
        check({tag, "_borrow"}, 32'(BORROW), 0);
        check({tag, "_zero"}, 32'(ZERO), 0);
        check({tag, "_valid"}, 32'(VALID), 0);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic calc_load);
        int         diff;
        logic       brw;
        logic [7:0] res;
        diff = int'(a) - int'(b);
        brw  = diff < 0;
`ifdef RESTA_SAT_EN
        res = brw ? 8'd0 : 8'(diff);
`else
        res = 8'((diff + 256) % 256);
`endif
        LOAD = 1'b1;
        DATA_IN = a;
        step;
        check("a_state", 32'(STATE), 1);
        check("a_reg", 32'(SUB_A), 32'(a));
        check("a_keep_b", 32'(SUB_B), 32'(last_b));
        check("a_valid", 32'(VALID), 0);
        DATA_IN = b;
        step;
        check("b_state", 32'(STATE), 2);
        check("b_reg", 32'(SUB_B), 32'(b));
        check("b_valid", 32'(VALID), 0);
        LOAD = calc_load;
        DATA_IN = 8'($urandom);
        step;
        LOAD = 1'b0;
        check("c_state", 32'(STATE), 3);
        check("c_sub_a", 32'(SUB_A), 32'(a));
        check("c_sub_b", 32'(SUB_B), 32'(b));
        check("c_result", 32'(RESULT), 32'(res));
        check("c_borrow", 32'(BORROW), 32'(brw));
        check("c_zero", 32'(ZERO), 32'(res == 8'd0));
        check("c_valid", 32'(VALID), 1);
        last_b = b;
    endtask

    initial begin
        step;
        expect_idle("rst");
        RST_N = 1'b1;
        step;
        expect_idle("idle");
        run_op(8'h64, 8'h25, 1'b1);
        run_op(8'h25, 8'h64, 1'b0);
        run_op(8'h55, 8'h55, 1'b0);
        LOAD = 1'b1;
        DATA_IN = 8'h10;
        step;
        LOAD = 1'b0;
        check("show_ld_state", 32'(STATE), 1);
        check("show_ld_valid", 32'(VALID), 0);
        check("show_ld_a", 32'(SUB_A), 32'h10);
        check("show_ld_b", 32'(SUB_B), 32'h55);
        CLEAR = 1'b1;
        LOAD = 1'b1;
        DATA_IN = 8'h77;
        step;
        CLEAR = 1'b0;
        LOAD = 1'b0;
        expect_idle("clr_b");
        last_b = 8'd0;
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'h00, 8'h01, 1'b0);
        run_op(8'h80, 8'h80, 1'b0);
        CLEAR = 1'b1;
        LOAD = 1'b1;
        step;
        CLEAR = 1'b0;
        LOAD = 1'b0;
        expect_idle("clr_show");
        last_b = 8'd0;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
            run_op(a, b, 1'($urandom));
        end
        run_op(8'h09, 8'h03, 1'b0);
        @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        expect_idle("arst");
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        last_b = 8'd0;
        repeat (3) step;
        check("post_rst_valid", 32'(VALID), 0);
        check("post_rst_state", 32'(STATE), 0);
        run_op(8'h12, 8'h34, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
